md_unit: RTL
============

Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the P7 five-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E and holds the architectural HI/LO registers.
- Drives the busy indication that the hazard/stall controller consumes: while an operation is in flight, MD instructions in D are held.
- Also accepts a cancel from the exception/interrupt logic so a flushed E-stage instruction has no effect.

Parameters:
- MUL_LAT, 5, cycles Busy stays high after a multiply is accepted.
- DIV_LAT, 10, cycles Busy stays high after a divide is accepted.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- MDOp  input  3  op from E: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
- A  input  32  forwarded rs value
- B  input  32  forwarded rt value
- Cancel  input  1  E-stage instruction flushed (interrupt/exception); suppresses everything this cycle
- Start  output  1  combinational: MDOp in 1..4, ~Cancel, ~Busy
- Busy  output  1  registered: operation in flight
- BusyOrStart  output  1  Start | Busy; to stall controller
- HI  output  32  architectural HI
- LO  output  32  architectural LO

Behaviour:
- Reset (reset==0 at posedge):
  - HI=0, LO=0, Busy=0.
  - state=IDLE, counter=0, pending result regs=0.
  - Any in-flight operation is discarded.
- States: IDLE, MUL_RUN, DIV_RUN. Busy = (state != IDLE).
- IDLE, Start with MDOp 1/2:
  - Compute 64-bit product {hi,lo} (signed for 1, unsigned for 2) into the pending regs.
  - counter=MUL_LAT-1; next state MUL_RUN.
- IDLE, Start with MDOp 3/4:
  - Compute quotient and remainder into pending regs.
  - counter=DIV_LAT-1; next state DIV_RUN.
- IDLE, MDOp 5/6 with ~Cancel: write A into HI (5) or LO (6) at this edge. Busy stays 0.
- RUN states:
  - Decrement the counter each cycle.
  - When counter==0: HI/LO take the pending result at that edge and state goes to IDLE.
  - Busy is therefore high for exactly MUL_LAT / DIV_LAT cycles. New HI/LO are visible in the first cycle Busy is 0.
- Ops arriving while Busy (any MDOp 1..6) are ignored. The stall controller guarantees none arrive; the bench asserts this.
- Cancel=1: Start=0; no state, HI or LO change from MDOp this cycle. An already running operation continues and completes normally.
- Signed divide:
  - Quotient truncates toward zero; LO=quotient, HI=remainder.
  - Remainder takes the sign of the dividend (A).
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (B==0), signed or unsigned: operation still runs the full DIV_LAT busy period; HI and LO are left unchanged at completion.
- Unsigned ops treat A and B as 0..2^32-1.
- Reset asserted mid-operation: next edge returns to IDLE, Busy=0, HI=LO=0; the pending result is lost.
- No combinational path from MDOp to HI/LO.

Test Plan:
- Reset, then MULT A=0xFFFFFFFE (-2), B=3 for 1 cycle -> Start=1 and BusyOrStart=1 that cycle; Busy=1 for the next 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1.
- MTHI A=0x12345678, then MTLO A=0xCAFEBABE with Cancel=1 -> HI=0x12345678 next cycle; LO unchanged; Busy stays 0 throughout.
- DIV A=5, B=0 with HI=0x11, LO=0x22 beforehand -> Busy for 10 cycles; HI=0x11, LO=0x22 after. MULT with Cancel=1 -> Start=0, Busy stays 0.
- DIV started, reset driven low at busy cycle 4 -> next edge Busy=0, HI=LO=0. Also: MULT issued while Busy -> ignored, first result unaffected.

Source files
------------

// File: rtl/md_unit.sv
// ----------------------------------------------------------------------------
// md_unit -- multiply/divide unit for the E stage of the five-stage pipeline.
//
// Holds the architectural HI/LO registers and executes MULT, MULTU, DIV, DIVU,
// MTHI and MTLO. Multiplies and divides are computed at issue into pending
// registers and committed to HI/LO after a fixed busy period. This models the
// pipeline-visible latency of a multi-cycle unit.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset (0 = reset)
//   MDOp[2:0]    0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none
//   A[31:0]      forwarded rs value
//   B[31:0]      forwarded rt value
//   Cancel       E-stage instruction flushed; suppresses any effect of MDOp
//   Start        combinational: a multiply/divide is accepted this cycle
//   Busy         registered: an operation is in flight
//   BusyOrStart  Start | Busy, consumed by the stall controller
//   HI[31:0]     architectural HI
//   LO[31:0]     architectural LO
// ----------------------------------------------------------------------------
module md_unit #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cancel,
    output logic        Start,
    output logic        Busy,
    output logic        BusyOrStart,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CW      = $clog2(MAX_LAT) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    hi_q, hi_d;
    logic [31:0]    lo_q, lo_d;
    logic [31:0]    pend_hi_q, pend_hi_d;
    logic [31:0]    pend_lo_q, pend_lo_d;
    // Cleared for divide-by-zero so completion leaves HI/LO untouched.
    logic           pend_we_q, pend_we_d;

    logic           is_mul, is_div;
    logic [63:0]    prod;
    logic           div_signed;
    logic [31:0]    div_a, div_b, q_mag, r_mag, quo, rem;

    assign is_mul      = (MDOp == 3'd1) || (MDOp == 3'd2);
    assign is_div      = (MDOp == 3'd3) || (MDOp == 3'd4);
    assign Busy        = (state_q != IDLE);
    assign Start       = (is_mul || is_div) && !Cancel && !Busy;
    assign BusyOrStart = Start || Busy;
    assign HI          = hi_q;
    assign LO          = lo_q;

    // Full 64-bit product; sign- or zero-extending to 64 bits makes the
    // truncated 64x64 product exact for both signednesses.
    always_comb begin
        if (MDOp == 3'd1) begin
            prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        end else begin
            prod = {32'd0, A} * {32'd0, B};
        end
    end

    // Signed divide done on magnitudes so that 0x80000000 / -1 wraps to
    // 0x80000000 instead of hitting simulator-specific overflow behaviour.
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    always_comb begin
        div_signed = (MDOp == 3'd3);
        div_a      = (div_signed && A[31]) ? -A : A;
        div_b      = (div_signed && B[31]) ? -B : B;
        if (B == 32'd0) begin
            div_b = 32'd1;  // result discarded anyway; avoids X from /0
        end
        q_mag = div_a / div_b;
        r_mag = div_a % div_b;
        quo   = (div_signed && (A[31] ^ B[31])) ? -q_mag : q_mag;
        rem   = (div_signed && A[31]) ? -r_mag : r_mag;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;

        unique case (state_q)
            IDLE: begin
                if (Start && is_mul) begin
                    pend_hi_d = prod[63:32];
                    pend_lo_d = prod[31:0];
                    pend_we_d = 1'b1;
                    cnt_d     = CW'(MUL_LAT - 1);
                    state_d   = MUL_RUN;
                end else if (Start && is_div) begin
                    pend_hi_d = rem;
                    pend_lo_d = quo;
                    pend_we_d = (B != 32'd0);
                    cnt_d     = CW'(DIV_LAT - 1);
                    state_d   = DIV_RUN;
                end else if (!Cancel && MDOp == 3'd5) begin
                    hi_d = A;
                end else if (!Cancel && MDOp == 3'd6) begin
                    lo_d = A;
                end
            end
            MUL_RUN, DIV_RUN: begin
                // Incoming ops are ignored here; Cancel does not stop a run.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

endmodule
